// File: rtl/pkt_sched_pkg.sv
// Shared encodings, default geometry and select-width helper for pkt_buffer_sched.
package pkt_sched_pkg;

  localparam int unsigned DEF_NUM_BUF = 4;
  localparam int unsigned DEF_DATA_W  = 64;
  localparam int unsigned DEF_ROUTE_W = 24;

  localparam logic [1:0] IN_IDLE_ENC    = 2'd0;
  localparam logic [1:0] IN_GRANT_ENC   = 2'd1;
  localparam logic [1:0] IN_XFER_ENC    = 2'd2;
  localparam logic [1:0] IN_RELEASE_ENC = 2'd3;

  localparam logic [1:0] OUT_IDLE_ENC  = 2'd0;
  localparam logic [1:0] OUT_GRANT_ENC = 2'd1;
  localparam logic [1:0] OUT_DRAIN_ENC = 2'd2;

  // Index width for a select into n buffers; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_SEL_W = sel_width(DEF_NUM_BUF);

endpackage

// File: rtl/pkt_buffer_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, with wrap-around.
module rr_arbiter
  import pkt_sched_pkg::*;
#(
  parameter int unsigned N     = DEF_NUM_BUF,
  parameter int unsigned SEL_W = DEF_SEL_W
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     win_oh,
  output logic [SEL_W-1:0] win_idx
);

  logic [2*N-1:0] rot;
  logic           found;
  int unsigned    pos;

  // Rotating the doubled vector puts the candidate at ptr into bit 0.
  always_comb begin
    rot     = {req, req} >> ptr;
    found   = 1'b0;
    pos     = 0;
    win_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = 32'(ptr) + i;
        if (pos >= N) pos = pos - N;
        win_idx = SEL_W'(pos);
      end
    end
    win_oh = found ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;
  end

endmodule

// File: rtl/pkt_buffer_sched.sv
// Ingress dispatch to empty buffers and egress arbitration onto one output port.
// Optional packet counters are built when PKT_SCHED_STATS_EN is defined.
module pkt_buffer_sched
  import pkt_sched_pkg::*;
#(
  parameter int unsigned NUM_BUF = DEF_NUM_BUF,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ROUTE_W = DEF_ROUTE_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       src_req,
  output logic                       src_ack,
  input  logic [DATA_W-1:0]          src_data,
  input  logic [ROUTE_W-1:0]         src_pkt_route,
  input  logic                       src_wr,
  output logic [NUM_BUF-1:0]         buf_in_req,
  input  logic [NUM_BUF-1:0]         buf_in_ack,
  input  logic [NUM_BUF-1:0]         buf_in_empty,
  output logic [DATA_W-1:0]          buf_in_data,
  output logic [ROUTE_W-1:0]         buf_in_pkt_route,
  output logic [NUM_BUF-1:0]         buf_in_wr,
  input  logic [NUM_BUF-1:0]         buf_out_req,
  output logic [NUM_BUF-1:0]         buf_out_ack,
  input  logic [NUM_BUF*DATA_W-1:0]  buf_out_data,
  input  logic [NUM_BUF*ROUTE_W-1:0] buf_out_pkt_route,
  input  logic [NUM_BUF-1:0]         buf_out_wr,
  input  logic [NUM_BUF-1:0]         buf_out_bop,
  input  logic [NUM_BUF-1:0]         buf_out_eop,
  output logic [NUM_BUF-1:0]         buf_out_rdy,
  output logic [DATA_W-1:0]          dst_data,
  output logic [ROUTE_W-1:0]         dst_pkt_route,
  output logic                       dst_wr,
  output logic                       dst_bop,
  output logic                       dst_eop,
  input  logic                       dst_rdy
`ifdef PKT_SCHED_STATS_EN
  ,
  output logic [31:0]                stat_in_pkts,
  output logic [31:0]                stat_out_pkts
`endif
);

  localparam int unsigned SEL_W = sel_width(NUM_BUF);

  typedef enum logic [1:0] {
    IN_IDLE    = IN_IDLE_ENC,
    IN_GRANT   = IN_GRANT_ENC,
    IN_XFER    = IN_XFER_ENC,
    IN_RELEASE = IN_RELEASE_ENC
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_IDLE  = OUT_IDLE_ENC,
    OUT_GRANT = OUT_GRANT_ENC,
    OUT_DRAIN = OUT_DRAIN_ENC
  } out_state_e;

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] s);
    return (32'(s) == NUM_BUF - 1) ? '0 : s + SEL_W'(1);
  endfunction

  in_state_e          in_state;
  out_state_e         out_state;
  logic [SEL_W-1:0]   in_sel, in_ptr, out_sel, out_ptr;
  logic [NUM_BUF-1:0] in_win_oh, out_win_oh;
  logic [SEL_W-1:0]   in_win_idx, out_win_idx;
  logic [NUM_BUF-1:0] in_oh, out_oh, out_grant_oh;
  logic               in_xfer;

  rr_arbiter #(.N(NUM_BUF), .SEL_W(SEL_W)) u_in_arb (
    .req     (buf_in_empty & {NUM_BUF{src_req}}),
    .ptr     (in_ptr),
    .win_oh  (in_win_oh),
    .win_idx (in_win_idx)
  );

  rr_arbiter #(.N(NUM_BUF), .SEL_W(SEL_W)) u_out_arb (
    .req     (buf_out_req),
    .ptr     (out_ptr),
    .win_oh  (out_win_oh),
    .win_idx (out_win_idx)
  );

  assign in_oh  = {{(NUM_BUF-1){1'b0}}, 1'b1} << in_sel;
  assign out_oh = {{(NUM_BUF-1){1'b0}}, 1'b1} << out_sel;

  // Ingress: claim an empty buffer, hold it for the whole packet, wait for its ack to drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_state <= IN_IDLE;
      in_sel   <= '0;
      in_ptr   <= '0;
    end else begin
      case (in_state)
        IN_IDLE: if (|in_win_oh) begin
          in_sel   <= in_win_idx;
          in_state <= IN_GRANT;
        end
        IN_GRANT: if (|(buf_in_ack & in_oh)) in_state <= IN_XFER;
        IN_XFER: if (!src_req) begin
          in_ptr   <= next_idx(in_sel);
          in_state <= IN_RELEASE;
        end
        IN_RELEASE: if (!(|(buf_in_ack & in_oh))) in_state <= IN_IDLE;
        default: in_state <= IN_IDLE;
      endcase
    end
  end

  // Egress: grant until the buffer drops its request, then one drain cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_state <= OUT_IDLE;
      out_sel   <= '0;
      out_ptr   <= '0;
    end else begin
      case (out_state)
        OUT_IDLE: if (|out_win_oh) begin
          out_sel   <= out_win_idx;
          out_state <= OUT_GRANT;
        end
        OUT_GRANT: if (!(|(buf_out_req & out_oh))) out_state <= OUT_DRAIN;
        OUT_DRAIN: begin
          out_ptr   <= next_idx(out_sel);
          out_state <= OUT_IDLE;
        end
        default: out_state <= OUT_IDLE;
      endcase
    end
  end

  assign in_xfer          = (in_state == IN_XFER);
  assign src_ack          = in_xfer;
  assign buf_in_req       = (in_state == IN_GRANT || in_xfer) ? in_oh : '0;
  assign buf_in_wr        = (in_xfer && src_wr) ? in_oh : '0;
  assign buf_in_data      = in_xfer ? src_data : '0;
  assign buf_in_pkt_route = in_xfer ? src_pkt_route : '0;

  assign out_grant_oh = (out_state == OUT_GRANT) ? out_oh : '0;
  assign buf_out_ack  = out_grant_oh;
  assign buf_out_rdy  = out_grant_oh & {NUM_BUF{dst_rdy}};

  // Output mux is driven only while a grant is held, so idle cycles present all-zero.
  always_comb begin
    dst_data      = '0;
    dst_pkt_route = '0;
    dst_wr        = 1'b0;
    dst_bop       = 1'b0;
    dst_eop       = 1'b0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (out_grant_oh[i]) begin
        dst_data      = buf_out_data[i*DATA_W +: DATA_W];
        dst_pkt_route = buf_out_pkt_route[i*ROUTE_W +: ROUTE_W];
        dst_wr        = buf_out_wr[i];
        dst_bop       = buf_out_bop[i];
        dst_eop       = buf_out_eop[i];
      end
    end
  end

`ifdef PKT_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_in_pkts  <= '0;
      stat_out_pkts <= '0;
    end else begin
      if (in_xfer && !src_req) stat_in_pkts <= stat_in_pkts + 32'd1;
      if (dst_wr && dst_eop) stat_out_pkts <= stat_out_pkts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_buffer_sched.sv
// Directed bench for pkt_buffer_sched (default 4 buffers, 64-bit data, 24-bit route).
module tb_pkt_buffer_sched;

  localparam int unsigned NB = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned RW = 24;

  logic            clk, reset;
  logic            src_req, src_ack, src_wr;
  logic [DW-1:0]   src_data, buf_in_data, dst_data;
  logic [RW-1:0]   src_pkt_route, buf_in_pkt_route, dst_pkt_route;
  logic [NB-1:0]   buf_in_req, buf_in_ack, buf_in_empty, buf_in_wr;
  logic [NB-1:0]   buf_out_req, buf_out_ack, buf_out_wr, buf_out_bop, buf_out_eop, buf_out_rdy;
  logic [NB*DW-1:0] buf_out_data;
  logic [NB*RW-1:0] buf_out_pkt_route;
  logic            dst_wr, dst_bop, dst_eop, dst_rdy;
  logic            in_ack_en;
`ifdef PKT_SCHED_STATS_EN
  logic [31:0]     stat_in_pkts, stat_out_pkts;
`endif

  int checks = 0;
  int failures = 0;
  int wr_cnt[NB];
  int pktnum = 0;

  pkt_buffer_sched dut (
    .clk(clk), .reset(reset),
    .src_req(src_req), .src_ack(src_ack), .src_data(src_data),
    .src_pkt_route(src_pkt_route), .src_wr(src_wr),
    .buf_in_req(buf_in_req), .buf_in_ack(buf_in_ack), .buf_in_empty(buf_in_empty),
    .buf_in_data(buf_in_data), .buf_in_pkt_route(buf_in_pkt_route), .buf_in_wr(buf_in_wr),
    .buf_out_req(buf_out_req), .buf_out_ack(buf_out_ack), .buf_out_data(buf_out_data),
    .buf_out_pkt_route(buf_out_pkt_route), .buf_out_wr(buf_out_wr),
    .buf_out_bop(buf_out_bop), .buf_out_eop(buf_out_eop), .buf_out_rdy(buf_out_rdy),
    .dst_data(dst_data), .dst_pkt_route(dst_pkt_route), .dst_wr(dst_wr),
    .dst_bop(dst_bop), .dst_eop(dst_eop), .dst_rdy(dst_rdy)
`ifdef PKT_SCHED_STATS_EN
    , .stat_in_pkts(stat_in_pkts), .stat_out_pkts(stat_out_pkts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffers acknowledge ingress requests combinationally.
  assign buf_in_ack = buf_in_req & {NB{in_ack_en}};

  always @(posedge clk)
    for (int i = 0; i < NB; i++) if (buf_in_wr[i]) wr_cnt[i] <= wr_cnt[i] + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_src_ack"}, 64'(src_ack), 0);
    check({tag, "_buf_in_req"}, 64'(buf_in_req), 0);
    check({tag, "_buf_in_wr"}, 64'(buf_in_wr), 0);
    check({tag, "_buf_in_data"}, buf_in_data, 0);
    check({tag, "_buf_in_route"}, 64'(buf_in_pkt_route), 0);
    check({tag, "_buf_out_ack"}, 64'(buf_out_ack), 0);
    check({tag, "_buf_out_rdy"}, 64'(buf_out_rdy), 0);
    check({tag, "_dst_data"}, dst_data, 0);
    check({tag, "_dst_route"}, 64'(dst_pkt_route), 0);
    check({tag, "_dst_strobes"}, 64'({dst_wr, dst_bop, dst_eop}), 0);
  endtask

  function automatic logic [DW-1:0] junk_data(input int b);
    return 64'hBAD0_0000_0000_0000 | 64'(b);
  endfunction

  task automatic set_lane_junk(input int b);
    buf_out_data[b*DW +: DW]      = junk_data(b);
    buf_out_pkt_route[b*RW +: RW] = 24'hEEEE00 | 24'(b);
    buf_out_wr[b]  = 1'b1;
    buf_out_bop[b] = 1'b1;
    buf_out_eop[b] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One ingress packet: request, wait for ack, stream words, release.
  task automatic in_pkt(input logic [3:0] empty, input int words, input logic [3:0] exp_oh);
    int lat;
    int base[NB];
    logic [3:0] got;
    pktnum++;
    for (int i = 0; i < NB; i++) base[i] = wr_cnt[i];
    buf_in_empty = empty;
    src_req = 1'b1;
    src_wr = 1'b1;
    src_data = 64'hDEAD_BEEF_0000_0000;
    got = '0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!src_ack) begin
        if (buf_in_req != 0) got = buf_in_req;
        check("in_wr_before_ack", 64'(buf_in_wr), 0);
      end
    end while (!src_ack && lat < 20);
    check("in_ack_seen", 64'(src_ack), 1);
    check("in_ack_latency", 64'(lat), 2);
    check("in_grant", 64'(got), 64'(exp_oh));
    src_wr = 1'b0;
    for (int w = 0; w < words && src_ack; w++) begin
      src_wr = 1'b1;
      src_data = {32'h1234_0000, 16'(pktnum), 16'(w)};
      src_pkt_route = 24'hA50000 | 24'(pktnum);
      #1;
      check("in_wr_steer", 64'(buf_in_wr), 64'(exp_oh));
      check("in_data", buf_in_data, src_data);
      check("in_route", 64'(buf_in_pkt_route), 64'(src_pkt_route));
      @(posedge clk); #1;
    end
    src_wr = 1'b0;
    src_req = 1'b0;
    @(posedge clk); #1;
    check("in_release_req", 64'(buf_in_req), 0);
    @(posedge clk); #1;
    for (int i = 0; i < NB; i++)
      check("in_wr_count", 64'(wr_cnt[i] - base[i]), exp_oh[i] ? 64'(words) : 64'd0);
  endtask

  // One egress packet from buffer b; toggle makes dst_rdy alternate every cycle.
  task automatic serve_out(input int b, input int words, input bit toggle);
    logic [3:0] oh;
    int k, cyc;
    oh = 4'b0001 << b;
    buf_out_req = buf_out_req | oh;
    @(posedge clk); #1;
    check("out_ack", 64'(buf_out_ack), 64'(oh));
    k = 0;
    cyc = 0;
    while (k < words && cyc < 50) begin
      dst_rdy = toggle ? cyc[0] : 1'b1;
      buf_out_data[b*DW +: DW]      = {32'hD000_0000, 16'(b), 16'(k)};
      buf_out_pkt_route[b*RW +: RW] = 24'hC00000 | 24'(b);
      buf_out_wr[b]  = 1'b1;
      buf_out_bop[b] = (k == 0);
      buf_out_eop[b] = (k == words - 1);
      #1;
      check("out_dst_data", dst_data, {32'hD000_0000, 16'(b), 16'(k)});
      check("out_dst_route", 64'(dst_pkt_route), 64'(24'hC00000 | 24'(b)));
      check("out_dst_strobes", 64'({dst_wr, dst_bop, dst_eop}), 64'({1'b1, k == 0, k == words - 1}));
      check("out_rdy_mirror", 64'(buf_out_rdy), 64'(dst_rdy ? oh : 4'b0));
      if (dst_rdy) k++;
      @(posedge clk); #1;
      cyc++;
    end
    check("out_words_done", 64'(k), 64'(words));
    buf_out_req = buf_out_req & ~oh;
    set_lane_junk(b);
    dst_rdy = 1'b1;
    @(posedge clk); #1;
    check("out_drain_ack", 64'(buf_out_ack), 0);
    check("out_drain_wr", 64'(dst_wr), 0);
    check("out_drain_data", dst_data, 0);
    check("out_drain_rdy", 64'(buf_out_rdy), 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0] empty;
    int         words;
    logic [3:0] exp_oh;
  } in_vec_t;

  in_vec_t tbl[10];

  initial begin
    logic [3:0] exp_order[5];
    logic [3:0] a, prev;
    int gidx, held, gap;
    bit seen;

    // Pointer walk: 0,1,2,3 round robin, then masked picks from the advancing pointer.
    tbl[0] = '{4'b1111, 3, 4'b0001};
    tbl[1] = '{4'b1111, 3, 4'b0010};
    tbl[2] = '{4'b1111, 3, 4'b0100};
    tbl[3] = '{4'b1111, 3, 4'b1000};
    tbl[4] = '{4'b0100, 2, 4'b0100};
    tbl[5] = '{4'b0011, 1, 4'b0001};
    tbl[6] = '{4'b1001, 4, 4'b1000};
    tbl[7] = '{4'b0010, 3, 4'b0010};
    tbl[8] = '{4'b0001, 5, 4'b0001};
    tbl[9] = '{4'b1111, 2, 4'b0010};
    exp_order[0] = 4'b0001;
    exp_order[1] = 4'b0010;
    exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000;
    exp_order[4] = 4'b0001;

    for (int i = 0; i < NB; i++) wr_cnt[i] = 0;
    reset = 1'b1;
    src_req = 1'b0;
    src_wr = 1'b1;
    src_data = 64'h5555_AAAA_5555_AAAA;
    src_pkt_route = 24'h123456;
    buf_in_empty = 4'b1111;
    in_ack_en = 1'b1;
    buf_out_req = '0;
    dst_rdy = 1'b1;
    for (int b = 0; b < NB; b++) set_lane_junk(b);
    do_reset();
    check_all_zero("reset");
    src_wr = 1'b0;

    for (int t = 0; t < 10; t++) in_pkt(tbl[t].empty, tbl[t].words, tbl[t].exp_oh);

    // No empty buffer: the request must sit unacknowledged.
    buf_in_empty = '0;
    src_req = 1'b1;
    src_wr = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (src_ack || buf_in_req != 0 || buf_in_wr != 0) seen = 1'b1;
    end
    check("full_no_ack", 64'(seen), 0);
    src_req = 1'b0;
    src_wr = 1'b0;
    @(posedge clk); #1;

`ifdef PKT_SCHED_STATS_EN
    for (int p = 0; p < 10; p++) serve_out(p % NB, 2, 1'b0);
    check("stat_in_pkts", 64'(stat_in_pkts), 10);
    check("stat_out_pkts", 64'(stat_out_pkts), 10);
`endif

    do_reset();

    // All buffers keep requesting; each drops its request after two granted cycles.
    buf_out_req = 4'b1111;
    gidx = 0;
    held = 0;
    gap = 0;
    prev = '0;
    for (int c = 0; c < 60 && gidx < 5; c++) begin
      @(posedge clk); #1;
      a = buf_out_ack;
      if (a != 0) begin
        if (prev == 0) begin
          check("fair_order", 64'(a), 64'(exp_order[gidx]));
          if (gidx > 0) check("fair_gap", 64'(gap >= 1), 1);
          gidx++;
          held = 0;
          gap = 0;
        end
        held++;
        if (held == 2) buf_out_req = buf_out_req & ~a;
      end else begin
        gap++;
        buf_out_req = 4'b1111;
      end
      prev = a;
    end
    check("fair_grants", 64'(gidx), 5);
    buf_out_req = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("fair_idle_ack", 64'(buf_out_ack), 0);

    serve_out(2, 5, 1'b1);

    // Concurrent ingress into buffer 1 and egress from buffer 3.
    fork
      in_pkt(4'b0010, 4, 4'b0010);
      serve_out(3, 4, 1'b0);
    join

    // Reset in the middle of both an ingress and an egress packet.
    buf_in_empty = 4'b1111;
    src_req = 1'b1;
    buf_out_req = 4'b0001;
    for (int c = 0; c < 10 && !src_ack; c++) begin
      @(posedge clk); #1;
    end
    src_wr = 1'b1;
    src_data = 64'h0F0F_0F0F_0F0F_0F0F;
    dst_rdy = 1'b1;
    #1;
    check("pre_reset_in_wr", 64'(buf_in_wr), 64'(4'b0100));
    check("pre_reset_out_ack", 64'(buf_out_ack), 64'(4'b0001));
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midreset");
    src_req = 1'b0;
    src_wr = 1'b0;
    buf_out_req = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    in_pkt(4'b1111, 2, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
